// File: rtl/irq_priority_sequencer.sv
// irq_priority_sequencer: synchronizes external IRQ pins and detects events on them.
// It holds a pending flag per channel and serves the highest-priority eligible
// channel through either the CPU exception handshake or the DTC activation handshake.
module irq_priority_sequencer #(
    parameter int N_IRQ    = 8,
    parameter int VEC_W    = 8,
    parameter int VEC_BASE = 64
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [N_IRQ-1:0]          irq_pin,
    input  logic [2*N_IRQ-1:0]        iscr,
    input  logic [N_IRQ-1:0]          ier,
    input  logic [N_IRQ-1:0]          dtce,
    input  logic                      cpu_mask,
    input  logic                      isr_wren,
    input  logic [N_IRQ-1:0]          isr_wdata,
    output logic [N_IRQ-1:0]          isr_rdata,
    output logic                      cpu_int_req,
    output logic [VEC_W-1:0]          cpu_int_vec,
    input  logic                      cpu_int_ack,
    output logic                      dtc_req,
    output logic [$clog2(N_IRQ)-1:0]  dtc_ch,
    input  logic                      dtc_ack
);

    localparam int CH_W = $clog2(N_IRQ);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CPU_REQ = 2'd1,
        DTC_REQ = 2'd2,
        GAP     = 2'd3
    } state_t;

    logic [N_IRQ-1:0] s1_q, s2_q, s3_q;
    logic [N_IRQ-1:0] s1_d, s2_d, s3_d;
    logic [N_IRQ-1:0] isr_q, isr_d;
    logic [N_IRQ-1:0] evt;
    logic [N_IRQ-1:0] fall_v, rise_v, level_v;
    logic [N_IRQ-1:0] wr_clr, ack_clr;
    logic [N_IRQ-1:0] eligible;
    logic             win_found;
    logic [CH_W-1:0]  win_idx;

    state_t           state_q, state_d;
    logic [CH_W-1:0]  ch_q, ch_d;
    logic             cpu_int_req_q, cpu_int_req_d;
    logic [VEC_W-1:0] cpu_int_vec_q, cpu_int_vec_d;
    logic             dtc_req_q, dtc_req_d;
    logic [CH_W-1:0]  dtc_ch_q, dtc_ch_d;

    // Event detection per channel from the synchronized level and its history
    always_comb begin
        s1_d    = irq_pin;
        s2_d    = s1_q;
        s3_d    = s2_q;
        fall_v  = s3_q & ~s2_q;
        rise_v  = ~s3_q & s2_q;
        level_v = ~s2_q;
        evt     = '0;
        for (int i = 0; i < N_IRQ; i++) begin
            case (iscr[2*i +: 2])
                2'b00:   evt[i] = level_v[i];
                2'b01:   evt[i] = fall_v[i];
                2'b10:   evt[i] = rise_v[i];
                default: evt[i] = fall_v[i] | rise_v[i];
            endcase
        end
    end

    // Flag update: clears from CPU writes and acks, a same-cycle event overrides them
    always_comb begin
        wr_clr = isr_wren ? ~isr_wdata : '0;
        isr_d  = (isr_q & ~wr_clr & ~ack_clr) | evt;
    end

    // Fixed-priority pick among channels that can be served right now (lowest index wins)
    always_comb begin
        eligible  = isr_q & ier & (dtce | {N_IRQ{~cpu_mask}});
        win_found = 1'b0;
        win_idx   = '0;
        for (int i = N_IRQ - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                win_found = 1'b1;
                win_idx   = CH_W'(i);
            end
        end
    end

    // Sequencer next state: commit a winner, hold the request until its matching ack
    always_comb begin
        state_d       = state_q;
        ch_d          = ch_q;
        cpu_int_req_d = cpu_int_req_q;
        cpu_int_vec_d = cpu_int_vec_q;
        dtc_req_d     = dtc_req_q;
        dtc_ch_d      = dtc_ch_q;
        ack_clr       = '0;
        case (state_q)
            IDLE: begin
                if (win_found) begin
                    ch_d = win_idx;
                    if (dtce[win_idx]) begin
                        state_d   = DTC_REQ;
                        dtc_req_d = 1'b1;
                        dtc_ch_d  = win_idx;
                    end else begin
                        state_d       = CPU_REQ;
                        cpu_int_req_d = 1'b1;
                        cpu_int_vec_d = VEC_W'(VEC_BASE) + VEC_W'(win_idx);
                    end
                end
            end
            CPU_REQ: begin
                if (cpu_int_ack) begin
                    ack_clr[ch_q] = 1'b1;
                    cpu_int_req_d = 1'b0;
                    state_d       = GAP;
                end
            end
            DTC_REQ: begin
                if (dtc_ack) begin
                    ack_clr[ch_q] = 1'b1;
                    dtc_req_d     = 1'b0;
                    state_d       = GAP;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Pin synchronizers and history; reset high so reset release sees no edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= '1;
            s2_q <= '1;
            s3_q <= '1;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
            s3_q <= s3_d;
        end
    end

    // Pending flag register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            isr_q <= '0;
        end else begin
            isr_q <= isr_d;
        end
    end

    // Sequencer state and registered handshake outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            ch_q          <= '0;
            cpu_int_req_q <= 1'b0;
            cpu_int_vec_q <= '0;
            dtc_req_q     <= 1'b0;
            dtc_ch_q      <= '0;
        end else begin
            state_q       <= state_d;
            ch_q          <= ch_d;
            cpu_int_req_q <= cpu_int_req_d;
            cpu_int_vec_q <= cpu_int_vec_d;
            dtc_req_q     <= dtc_req_d;
            dtc_ch_q      <= dtc_ch_d;
        end
    end

    assign isr_rdata   = isr_q;
    assign cpu_int_req = cpu_int_req_q;
    assign cpu_int_vec = cpu_int_vec_q;
    assign dtc_req     = dtc_req_q;
    assign dtc_ch      = dtc_ch_q;

endmodule

// File: tb/tb_irq_priority_sequencer.sv
// Directed testbench for irq_priority_sequencer with hand-computed expectations.
module tb_irq_priority_sequencer;

    localparam int N = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [N-1:0]  irq_pin = '1;
    logic [2*N-1:0] iscr = '0;
    logic [N-1:0]  ier = '0;
    logic [N-1:0]  dtce = '0;
    logic          cpu_mask = 1'b0;
    logic          isr_wren = 1'b0;
    logic [N-1:0]  isr_wdata = '1;
    logic [N-1:0]  isr_rdata;
    logic          cpu_int_req;
    logic [7:0]    cpu_int_vec;
    logic          cpu_int_ack = 1'b0;
    logic          dtc_req;
    logic [2:0]    dtc_ch;
    logic          dtc_ack = 1'b0;

    int total = 0;
    int bad = 0;

    irq_priority_sequencer #(.N_IRQ(N), .VEC_W(8), .VEC_BASE(64)) dut (
        .clk(clk), .rst_n(rst_n), .irq_pin(irq_pin), .iscr(iscr), .ier(ier),
        .dtce(dtce), .cpu_mask(cpu_mask), .isr_wren(isr_wren), .isr_wdata(isr_wdata),
        .isr_rdata(isr_rdata), .cpu_int_req(cpu_int_req), .cpu_int_vec(cpu_int_vec),
        .cpu_int_ack(cpu_int_ack), .dtc_req(dtc_req), .dtc_ch(dtc_ch), .dtc_ack(dtc_ack)
    );

    always #5 clk = ~clk;

    // Advance past a rising edge and settle before sampling or driving
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic [N-1:0] pins);
        irq_pin = pins;
    endtask

    task automatic doReset();
        @(negedge clk);
        rst_n = 1'b0;
        irq_pin = '1; iscr = '0; ier = '0; dtce = '0; cpu_mask = 1'b0;
        isr_wren = 1'b0; isr_wdata = '1; cpu_int_ack = 1'b0; dtc_ack = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    // Bounded wait for a request on the chosen path
    task automatic waitReq(input bit forDtc);
        for (int i = 0; i < 12; i++) begin
            if (forDtc ? dtc_req : cpu_int_req) break;
            tick();
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        doReset();
        checkOutput("rst_isr", isr_rdata, 0);
        checkOutput("rst_cpu_req", cpu_int_req, 0);
        checkOutput("rst_cpu_vec", cpu_int_vec, 0);
        checkOutput("rst_dtc_req", dtc_req, 0);
        checkOutput("rst_dtc_ch", dtc_ch, 0);

        // Falling edge on ch3 via the CPU path, with exact latency
        iscr[7:6] = 2'b01; ier[3] = 1'b1;
        applyStimulus(8'hF7);
        tick(); checkOutput("fe_isr_k", isr_rdata, 0);
        tick(); checkOutput("fe_isr_k1", isr_rdata, 0);
        tick(); checkOutput("fe_isr_k2", isr_rdata, 8'h08);
        checkOutput("fe_req_k2", cpu_int_req, 0);
        tick(); checkOutput("fe_req_k3", cpu_int_req, 1);
        checkOutput("fe_vec", cpu_int_vec, 67);
        tick(); checkOutput("fe_req_hold", cpu_int_req, 1);
        cpu_int_ack = 1'b1;
        tick(); cpu_int_ack = 1'b0;
        checkOutput("fe_ack_isr", isr_rdata, 0);
        checkOutput("fe_ack_req", cpu_int_req, 0);
        tick(); checkOutput("fe_gap_req", cpu_int_req, 0);

        // Masked CPU winner lets a lower-priority DTC channel through
        doReset();
        iscr[5:4] = 2'b01; iscr[11:10] = 2'b01; ier = 8'h24; dtce[5] = 1'b1; cpu_mask = 1'b1;
        applyStimulus(8'hDB);
        tick(); tick(); tick();
        checkOutput("pm_isr", isr_rdata, 8'h24);
        tick();
        checkOutput("pm_dtc_req", dtc_req, 1);
        checkOutput("pm_dtc_ch", dtc_ch, 5);
        checkOutput("pm_cpu_req", cpu_int_req, 0);
        dtc_ack = 1'b1;
        tick(); dtc_ack = 1'b0; cpu_mask = 1'b0;
        checkOutput("pm_dtc_drop", dtc_req, 0);
        checkOutput("pm_isr_after", isr_rdata, 8'h04);
        tick();
        checkOutput("pm_gap", cpu_int_req, 0);
        tick();
        checkOutput("pm_cpu_req2", cpu_int_req, 1);
        checkOutput("pm_cpu_vec2", cpu_int_vec, 66);
        cpu_int_ack = 1'b1; tick(); cpu_int_ack = 1'b0;
        checkOutput("pm_isr_end", isr_rdata, 0);

        // Level mode on ch0: flag re-sets while the pin stays low
        doReset();
        ier[0] = 1'b1;
        applyStimulus(8'hFE);
        for (int n = 0; n < 3; n++) begin
            waitReq(1'b0);
            checkOutput("lv_req", cpu_int_req, 1);
            checkOutput("lv_vec", cpu_int_vec, 64);
            cpu_int_ack = 1'b1; tick(); cpu_int_ack = 1'b0;
            checkOutput("lv_req_drop", cpu_int_req, 0);
            checkOutput("lv_isr_reset", isr_rdata, 8'h01);
        end
        applyStimulus(8'hFF);
        for (int i = 0; i < 12; i++) begin
            if (cpu_int_req) begin
                cpu_int_ack = 1'b1; tick(); cpu_int_ack = 1'b0;
            end else begin
                tick();
            end
        end
        checkOutput("lv_final_isr", isr_rdata, 0);
        checkOutput("lv_final_req", cpu_int_req, 0);

        // Write-clear colliding with a rising event on ch1: set wins
        doReset();
        iscr[3:2] = 2'b10;
        applyStimulus(8'hFD);
        tick(); tick(); tick();
        checkOutput("sc_no_fall_evt", isr_rdata, 0);
        applyStimulus(8'hFF);
        tick(); tick();
        isr_wren = 1'b1; isr_wdata = 8'hFD;
        tick(); isr_wren = 1'b0; isr_wdata = '1;
        checkOutput("sc_set_wins", isr_rdata, 8'h02);
        isr_wren = 1'b1; isr_wdata = 8'hFD;
        tick(); isr_wren = 1'b0; isr_wdata = '1;
        checkOutput("sc_clear", isr_rdata, 0);

        // Committed request on ch4 survives ier and ISR changes; stray DTC ack ignored
        doReset();
        iscr[9:8] = 2'b01; ier[4] = 1'b1;
        applyStimulus(8'hEF);
        waitReq(1'b0);
        checkOutput("cm_req", cpu_int_req, 1);
        checkOutput("cm_vec", cpu_int_vec, 68);
        ier[4] = 1'b0; isr_wren = 1'b1; isr_wdata = 8'hEF;
        tick(); isr_wren = 1'b0; isr_wdata = '1;
        checkOutput("cm_isr_cleared", isr_rdata, 0);
        checkOutput("cm_req_held", cpu_int_req, 1);
        checkOutput("cm_vec_held", cpu_int_vec, 68);
        dtc_ack = 1'b1; tick(); dtc_ack = 1'b0;
        checkOutput("cm_dtc_ack_ignored", cpu_int_req, 1);
        cpu_int_ack = 1'b1; tick(); cpu_int_ack = 1'b0;
        checkOutput("cm_ack_drop", cpu_int_req, 0);

        // Async reset during a DTC request on ch6
        doReset();
        iscr[13:12] = 2'b01; ier[6] = 1'b1; dtce[6] = 1'b1;
        applyStimulus(8'hBF);
        waitReq(1'b1);
        checkOutput("ar_dtc_req", dtc_req, 1);
        checkOutput("ar_dtc_ch", dtc_ch, 6);
        #2;
        dtc_ack = 1'b1;
        rst_n = 1'b0;
        #1;
        checkOutput("ar_req_async", dtc_req, 0);
        checkOutput("ar_isr_async", isr_rdata, 0);
        dtc_ack = 1'b0;
        applyStimulus(8'hFF);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        checkOutput("ar_no_req", dtc_req, 0);
        checkOutput("ar_no_isr", isr_rdata, 0);
        applyStimulus(8'hBF);
        waitReq(1'b1);
        checkOutput("ar_new_req", dtc_req, 1);
        checkOutput("ar_new_ch", dtc_ch, 6);
        dtc_ack = 1'b1; tick(); dtc_ack = 1'b0;
        checkOutput("ar_new_drop", dtc_req, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
